// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one falling-edge write port, v0/a0 taps.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module mips_reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int V0_IDX = 2,
   parameter int A0_IDX = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] readRegister1,
   input  logic [ADDR_W-1:0] readRegister2,
   input  logic [ADDR_W-1:0] writeRegister,
   input  logic [DATA_W-1:0] writeData,
   input  logic              regWrite,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic [DATA_W-1:0] v0,
   output logic [DATA_W-1:0] a0
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] V0_SEL = ADDR_W'(V0_IDX);
   localparam logic [ADDR_W-1:0] A0_SEL = ADDR_W'(A0_IDX);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr_en;

   // Gating with reset_n keeps a bypassed value from leaking out while reset is held.
   assign wr_en = regWrite && reset_n && (writeRegister != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[writeRegister] = writeData;
      end
      regs_d[0] = '0;
   end

   // Commit on the falling edge so the result settles before the next PC update.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] val;
      val = (idx == '0) ? '0 : regs_q[idx];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (idx == writeRegister)) begin
         val = writeData;
      end
`endif
      return val;
   endfunction

   always_comb begin
      readData1 = read_port(readRegister1);
      readData2 = read_port(readRegister2);
      v0        = read_port(V0_SEL);
      a0        = read_port(A0_SEL);
   end

endmodule

// File: tb/tb_mips_reg_file.sv
// Randomized self-checking bench for mips_reg_file against an array-based register model.
// Bypass expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_mips_reg_file;

   logic        clock;
   logic        reset_n;
   logic [4:0]  readRegister1;
   logic [4:0]  readRegister2;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        regWrite;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic [31:0] v0;
   logic [31:0] a0;

   int checks;
   int errors;
   logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   mips_reg_file dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .readRegister1 (readRegister1),
      .readRegister2 (readRegister2),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .regWrite      (regWrite),
      .readData1     (readData1),
      .readData2     (readData2),
      .v0            (v0),
      .a0            (a0)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected read value before the pending write commits.
   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (BYPASS && reset_n && regWrite && writeRegister != 5'd0 && idx == writeRegister)
         return writeData;
      return model[idx];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   task automatic do_write(input logic [4:0] wr, input logic [31:0] wd, input logic en);
      @(posedge clock);
      #1;
      writeRegister = wr;
      writeData     = wd;
      regWrite      = en;
      @(negedge clock);
      #1;
      if (en && wr != 5'd0) model[wr] = wd;
      regWrite = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 1; i < 32; i++) do_write(5'(i), $urandom, 1'b1);
      @(posedge clock);
      #2;
      readRegister1 = 5'd7;
      readRegister2 = 5'd31;
      writeRegister = 5'd7;
      writeData     = 32'hCAFE_F00D;
      regWrite      = 1'b1;
      reset_n       = 1'b0;
      #1;
      checks++;
      if (readData1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want 0", readData1); end
      checks++;
      if (readData2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h want 0", readData2); end
      checks++;
      if (v0 !== 32'h0 || a0 !== 32'h0) begin errors++; $display("FAIL reset_taps got v0=%h a0=%h want 0", v0, a0); end
      @(negedge clock);
      #1;
      checks++;
      if (readData1 !== 32'h0) begin errors++; $display("FAIL reset_wins got %h want 0", readData1); end
      regWrite = 1'b0;
      reset_n  = 1'b1;
      clear_model();
      #1;
   endtask

   task automatic test_bypass();
      @(posedge clock);
      #1;
      regWrite      = 1'b1;
      writeRegister = 5'd5;
      writeData     = 32'hA5A5_A5A5;
      readRegister2 = 5'd5;
      #1;
      checks++;
      if (readData2 !== (BYPASS ? 32'hA5A5_A5A5 : 32'h0)) begin
         errors++; $display("FAIL bypass_pre got %h want %h", readData2, BYPASS ? 32'hA5A5_A5A5 : 32'h0);
      end
      @(negedge clock);
      #1;
      model[5] = 32'hA5A5_A5A5;
      regWrite = 1'b0;
      #1;
      checks++;
      if (readData2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_post got %h want a5a5a5a5", readData2); end
   endtask

   task automatic test_write_read();
      do_write(5'd8, 32'hDEAD_BEEF, 1'b1);
      readRegister1 = 5'd8;
      readRegister2 = 5'd8;
      #1;
      checks++;
      if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_read got %h/%h want deadbeef", readData1, readData2);
      end
   endtask

   task automatic test_write_disable();
      do_write(5'd9, 32'h1234_5678, 1'b0);
      readRegister1 = 5'd9;
      #1;
      checks++;
      if (readData1 !== 32'h0) begin errors++; $display("FAIL write_disable got %h want 0", readData1); end
   endtask

   task automatic test_zero_reg();
      do_write(5'd0, 32'hFFFF_FFFF, 1'b1);
      readRegister1 = 5'd0;
      #1;
      checks++;
      if (readData1 !== 32'h0) begin errors++; $display("FAIL zero_reg got %h want 0", readData1); end
   endtask

   task automatic test_taps();
      do_write(5'd2, 32'd1, 1'b1);
      do_write(5'd4, 32'd42, 1'b1);
      checks++;
      if (v0 !== 32'd1 || a0 !== 32'd42) begin errors++; $display("FAIL taps got v0=%0d a0=%0d want 1/42", v0, a0); end
      do_write(5'd2, 32'd10, 1'b1);
      checks++;
      if (v0 !== 32'd10 || a0 !== 32'd42) begin errors++; $display("FAIL taps_update got v0=%0d a0=%0d want 10/42", v0, a0); end
   endtask

   task automatic test_random();
      logic [31:0] e1, e2, ev0, ea0;
      for (int n = 0; n < 300; n++) begin
         @(posedge clock);
         #1;
         readRegister1 = 5'($urandom_range(31, 0));
         readRegister2 = (n % 5 == 0) ? readRegister1 : 5'($urandom_range(31, 0));
         writeRegister = (n % 3 == 0) ? readRegister1 : 5'($urandom_range(31, 0));
         if (n % 7 == 0) writeRegister = 5'd2;
         writeData     = $urandom;
         regWrite      = ($urandom_range(3, 0) != 0);
         #1;
         e1 = exp_read(readRegister1); e2 = exp_read(readRegister2);
         ev0 = exp_read(5'd2); ea0 = exp_read(5'd4);
         checks++;
         if (readData1 !== e1 || readData2 !== e2 || v0 !== ev0 || a0 !== ea0) begin
            errors++;
            $display("FAIL rand_pre n=%0d got %h %h %h %h want %h %h %h %h", n, readData1, readData2, v0, a0, e1, e2, ev0, ea0);
         end
         @(negedge clock);
         #1;
         if (regWrite && writeRegister != 5'd0) model[writeRegister] = writeData;
         e1 = exp_read(readRegister1); e2 = exp_read(readRegister2);
         ev0 = exp_read(5'd2); ea0 = exp_read(5'd4);
         checks++;
         if (readData1 !== e1 || readData2 !== e2 || v0 !== ev0 || a0 !== ea0) begin
            errors++;
            $display("FAIL rand_post n=%0d got %h %h %h %h want %h %h %h %h", n, readData1, readData2, v0, a0, e1, e2, ev0, ea0);
         end
      end
      regWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         readRegister1 = 5'(i);
         #1;
         checks++;
         if (readData1 !== model[i]) begin errors++; $display("FAIL sweep r%0d got %h want %h", i, readData1, model[i]); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_model();
      reset_n       = 1'b0;
      regWrite      = 1'b0;
      readRegister1 = '0;
      readRegister2 = '0;
      writeRegister = '0;
      writeData     = '0;
      #12;
      reset_n = 1'b1;
      test_reset();
      test_bypass();
      test_write_read();
      test_write_disable();
      test_zero_reg();
      test_taps();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- General-purpose register file for the single-cycle MIPS datapath: 32 x 32-bit registers.
- Two combinational read ports feed the ALU/operand muxes, and one write port commits the result.
- Two always-visible taps (v0, a0) feed the syscall unit.
- Sits between instruction decode (rs/rt fields, write-register mux) and the ALU/writeback path.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width; depth = 2**ADDR_W (32).
- V0_IDX, 2, index driven on v0 tap.
- A0_IDX, 4, index driven on a0 tap.

Ports:
- clock  input  1  system clock; writes commit on the falling edge.
- reset_n  input  1  asynchronous active-low reset.
- readRegister1  input  ADDR_W  read port 1 index (inst rs field).
- readRegister2  input  ADDR_W  read port 2 index (inst rt field).
- writeRegister  input  ADDR_W  write index (from rt/rd mux).
- writeData  input  DATA_W  data to write.
- regWrite  input  1  write enable, active high.
- readData1  output  DATA_W  contents of readRegister1.
- readData2  output  DATA_W  contents of readRegister2.
- v0  output  DATA_W  contents of register V0_IDX.
- a0  output  DATA_W  contents of register A0_IDX.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: reset_n low clears all 32 registers to 0 immediately, independent of clock. readData1, readData2, v0 and a0 read 0 while reset is held.
- Reset wins over a simultaneous write.
- Write:
  - On the falling edge of clock with reset_n high and regWrite=1: reg[writeRegister] <= writeData.
  - regWrite=0: no change.
  - Falling-edge commit lets the value be written mid-cycle and be stable before the next rising edge of the PC.
- Register 0:
  - Hardwired zero; writes to index 0 are ignored.
  - readDataN reads 0 for index 0.
  - If V0_IDX/A0_IDX were 0 the tap reads 0.
- Read:
  - Fully combinational, zero latency. readData1/2 track index or content changes in the same delta.
  - Both ports may address the same register; both return the same value.
- Taps: v0 and a0 are continuous combinational views of their registers. They update immediately after the committing falling edge.
- Read during write: without the optional feature, a read of the register being written returns the old value until the falling edge, then the new value.
- No X propagation: every register has a defined value after reset. Out-of-range indices cannot occur (full ADDR_W decode).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when regWrite=1, writeRegister!=0 and readRegisterN==writeRegister, readDataN = writeData combinationally, before the falling edge.
  - The same bypass applies to v0/a0 when writeRegister equals V0_IDX/A0_IDX.
- Undefined: no bypass; old value is visible until the falling-edge commit.

Test Plan:
- Reset: pulse reset_n low mid-cycle with arbitrary prior contents -> readData1, readData2, v0 and a0 read 0 immediately, with no clock edge needed.
- Write/read: write 0xDEADBEEF to r8 with regWrite=1, then readRegister1=8, readRegister2=8 after the falling edge -> both ports read 0xDEADBEEF.
- Write disable: regWrite=0, writeRegister=9, writeData=0x12345678 across a falling edge -> r9 still reads 0.
- Zero register: regWrite=1, writeRegister=0, writeData=0xFFFFFFFF -> readData1 with index 0 reads 0.
- Syscall taps:
  - Write r2=1, then r4=42 -> v0=1, a0=42.
  - Then write r2=10 -> v0=10; a0 stays 42.
- Bypass, REGFILE_BYPASS_EN defined: regWrite=1, writeRegister=5, writeData=0xA5A5A5A5, readRegister2=5, clock high -> readData2=0xA5A5A5A5 before the falling edge.
- Bypass, macro undefined: same stimulus -> readData2 holds the old value, 0, until the falling edge.
